reg_share_arbiter: RTL and testbench

REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

---
 rtl/reg_share_arbiter.sv | 110 +++++++++++
 tb/tb_reg_share_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/reg_share_arbiter.sv
// Two-requester arbiter guarding one shared data register.
// A requester wins the register in IDLE, gets exactly one LOAD cycle in which
// its data is captured, then holds ownership in WAIT until it drops its request.
// Simultaneous requests are resolved by a round-robin pointer that flips to the
// non-owner after every completed load.
module reg_share_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic [7:0]       load_cnt
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StWait = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;  // 0 = A, 1 = B
    logic             prio_q, prio_d;    // 0 = A first, 1 = B first
    logic [WIDTH-1:0] q_q, q_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             gnt_a_q, gnt_b_q, busy_q;
    logic             owner_req;

    // Next-state, capture and arbitration logic.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        prio_d    = prio_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        owner_req = owner_q ? req_b : req_a;
        case (state_q)
            StIdle: begin
                if (req_a && req_b) begin
                    owner_d = prio_q;
                    state_d = StLoad;
                end else if (req_a) begin
                    owner_d = 1'b0;
                    state_d = StLoad;
                end else if (req_b) begin
                    owner_d = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                q_d     = owner_q ? data_b : data_a;
                prio_d  = ~owner_q;
                state_d = StWait;
                if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StWait: begin
                // Owner keeps the register until it releases; no timeout.
                if (!owner_req) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register; grant/busy flops are loaded from next state so outputs
    // come straight from flops and line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            q_q     <= '0;
            cnt_q   <= 8'd0;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            gnt_a_q <= (state_d != StIdle) && !owner_d;
            gnt_b_q <= (state_d != StIdle) && owner_d;
            busy_q  <= (state_d != StIdle);
        end
    end

    // Output drive.
    always_comb begin
        gnt_a    = gnt_a_q;
        gnt_b    = gnt_b_q;
        busy     = busy_q;
        q        = q_q;
        load_cnt = cnt_q;
    end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench: a cycle-by-cycle vector table for the main scenarios plus
// hand-written sequences for long ownership and counter saturation.
module tb_reg_share_arbiter;

    localparam int NVEC = 30;

    logic       clk;
    logic       rst;
    logic       req_a;
    logic [7:0] data_a;
    logic       req_b;
    logic [7:0] data_b;
    logic       gnt_a;
    logic       gnt_b;
    logic [7:0] q;
    logic       busy;
    logic [7:0] load_cnt;

    int checks = 0;
    int errors = 0;

    reg_share_arbiter #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_a    (req_a),
        .data_a   (data_a),
        .req_b    (req_b),
        .data_b   (data_b),
        .gnt_a    (gnt_a),
        .gnt_b    (gnt_b),
        .q        (q),
        .busy     (busy),
        .load_cnt (load_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ra;
        logic [7:0] da;
        logic       rb;
        logic [7:0] db;
        logic       ega;
        logic       egb;
        logic       ebusy;
        logic [7:0] eq;
        logic [7:0] ecnt;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic r, input logic ra, input logic [7:0] da,
                                input logic rb, input logic [7:0] db, input logic ega,
                                input logic egb, input logic eb, input logic [7:0] eq,
                                input logic [7:0] ec);
        vec_t v;
        v.rst = r;   v.ra = ra;   v.da = da;   v.rb = rb;     v.db = db;
        v.ega = ega; v.egb = egb; v.ebusy = eb; v.eq = eq;    v.ecnt = ec;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input int idx, input logic ega, input logic egb,
                              input logic eb, input logic [7:0] eq, input logic [7:0] ec);
        check("gnt_a", idx, {31'd0, gnt_a}, {31'd0, ega});
        check("gnt_b", idx, {31'd0, gnt_b}, {31'd0, egb});
        check("busy", idx, {31'd0, busy}, {31'd0, eb});
        check("q", idx, {24'd0, q}, {24'd0, eq});
        check("load_cnt", idx, {24'd0, load_cnt}, {24'd0, ec});
        check("gnt_excl", idx, {31'd0, gnt_a & gnt_b}, 32'd0);
    endtask

    initial begin
        // Each row: inputs applied for one cycle, expected outputs after the edge.
        //            rst ra da     rb db     ga gb bz q      cnt
        vecs[0]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'd0);
        vecs[1]  = mk(0, 1, 8'hCF, 0, 8'h00, 1, 0, 1, 8'h00, 8'd0);  // LOAD A
        vecs[2]  = mk(0, 1, 8'hCF, 0, 8'h00, 1, 0, 1, 8'hCF, 8'd1);  // WAIT A
        vecs[3]  = mk(0, 1, 8'hCF, 0, 8'h00, 1, 0, 1, 8'hCF, 8'd1);
        vecs[4]  = mk(0, 0, 8'hCF, 0, 8'h00, 0, 0, 0, 8'hCF, 8'd1);  // release
        vecs[5]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'd0);
        vecs[6]  = mk(0, 1, 8'hFF, 1, 8'h89, 1, 0, 1, 8'h00, 8'd0);  // both: A first
        vecs[7]  = mk(0, 1, 8'hFF, 1, 8'h89, 1, 0, 1, 8'hFF, 8'd1);
        vecs[8]  = mk(0, 0, 8'hFF, 1, 8'h89, 0, 0, 0, 8'hFF, 8'd1);  // A releases
        vecs[9]  = mk(0, 0, 8'hFF, 1, 8'h89, 0, 1, 1, 8'hFF, 8'd1);  // LOAD B
        vecs[10] = mk(0, 0, 8'hFF, 1, 8'h89, 0, 1, 1, 8'h89, 8'd2);
        vecs[11] = mk(0, 0, 8'hFF, 0, 8'h89, 0, 0, 0, 8'h89, 8'd2);
        vecs[12] = mk(0, 1, 8'h11, 1, 8'h22, 1, 0, 1, 8'h89, 8'd2);  // prio A
        vecs[13] = mk(0, 1, 8'h11, 1, 8'h22, 1, 0, 1, 8'h11, 8'd3);
        vecs[14] = mk(0, 0, 8'h11, 1, 8'h22, 0, 0, 0, 8'h11, 8'd3);
        vecs[15] = mk(0, 1, 8'h11, 1, 8'h22, 0, 1, 1, 8'h11, 8'd3);  // prio B
        vecs[16] = mk(0, 1, 8'h11, 1, 8'h22, 0, 1, 1, 8'h22, 8'd4);
        vecs[17] = mk(0, 1, 8'h11, 0, 8'h22, 0, 0, 0, 8'h22, 8'd4);
        vecs[18] = mk(0, 1, 8'h11, 1, 8'h22, 1, 0, 1, 8'h22, 8'd4);  // prio A again
        vecs[19] = mk(0, 1, 8'h11, 1, 8'h22, 1, 0, 1, 8'h11, 8'd5);
        vecs[20] = mk(0, 1, 8'h01, 0, 8'h22, 1, 0, 1, 8'h11, 8'd5);  // data_a ignored
        vecs[21] = mk(0, 1, 8'h01, 1, 8'h22, 1, 0, 1, 8'h11, 8'd5);  // req_b ignored
        vecs[22] = mk(0, 1, 8'h02, 0, 8'h22, 1, 0, 1, 8'h11, 8'd5);
        vecs[23] = mk(0, 0, 8'h02, 0, 8'h22, 0, 0, 0, 8'h11, 8'd5);
        vecs[24] = mk(0, 0, 8'h02, 1, 8'h01, 0, 1, 1, 8'h11, 8'd5);  // LOAD B
        vecs[25] = mk(1, 0, 8'h02, 1, 8'h01, 0, 0, 0, 8'h00, 8'd0);  // rst aborts load
        vecs[26] = mk(0, 1, 8'hAA, 1, 8'hBB, 1, 0, 1, 8'h00, 8'd0);  // prio back to A
        vecs[27] = mk(0, 1, 8'hAA, 1, 8'hBB, 1, 0, 1, 8'hAA, 8'd1);
        vecs[28] = mk(1, 1, 8'hAA, 1, 8'hBB, 0, 0, 0, 8'h00, 8'd0);  // rst in WAIT
        vecs[29] = mk(0, 0, 8'hAA, 0, 8'hBB, 0, 0, 0, 8'h00, 8'd0);

        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; data_a = 8'h00; data_b = 8'h00;

        for (int i = 0; i < NVEC; i++) begin
            rst = vecs[i].rst; req_a = vecs[i].ra; data_a = vecs[i].da;
            req_b = vecs[i].rb; data_b = vecs[i].db;
            step();
            check_outs(i, vecs[i].ega, vecs[i].egb, vecs[i].ebusy, vecs[i].eq, vecs[i].ecnt);
        end

        // Long ownership: B holds for many cycles while data keeps changing.
        rst = 1'b0; req_a = 1'b0; req_b = 1'b1; data_b = 8'h3C;
        step();
        check_outs(100, 1'b0, 1'b1, 1'b1, 8'h00, 8'd0);
        step();
        check_outs(101, 1'b0, 1'b1, 1'b1, 8'h3C, 8'd1);
        for (int i = 0; i < 20; i++) begin
            data_b = 8'(i + 1);
            req_a  = i[0];
            step();
            check_outs(200 + i, 1'b0, 1'b1, 1'b1, 8'h3C, 8'd1);
        end
        req_a = 1'b0; req_b = 1'b0;
        step();
        check_outs(102, 1'b0, 1'b0, 1'b0, 8'h3C, 8'd1);

        // Saturation: 256 single-requester loads from a fresh reset, then one more.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            req_a = 1'b1; data_a = 8'(i);
            step();
            step();
            check("sat_q", i, {24'd0, q}, i);
            check("sat_cnt", i, {24'd0, load_cnt}, (i + 1 > 255) ? 255 : i + 1);
            req_a = 1'b0;
            step();
        end
        req_b = 1'b1; data_b = 8'h5A;
        step();
        step();
        check_outs(300, 1'b0, 1'b1, 1'b1, 8'h5A, 8'd255);
        req_b = 1'b0;
        step();
        check_outs(301, 1'b0, 1'b0, 1'b0, 8'h5A, 8'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
